// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - restoring digit-by-digit unsigned integer square root controller
module sqrt_seq_ctrl #(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_radicand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W/2-1:0]   out_root,
  output logic [W/2:0]     out_rem,
  output logic             out_exact,
  output logic             busy
);

  localparam int H  = W / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  // Odd widths or widths below 4 would break the two-bits-per-step shift.
  generate
    if (((W % 2) != 0) || (W < 4)) begin : g_bad_width
      $error("sqrt_seq_ctrl: W must be even and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    shift_q;
  logic [H+1:0]    rem_q;
  logic [H-1:0]    root_q;
  logic [CW-1:0]   cnt_q;

  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [H-1:0]    out_root_q;
  logic [H:0]      out_rem_q;
  logic            out_exact_q;

  logic [H+1:0]    rem_t;
  logic [H+1:0]    trial;
  logic            take;
  logic [H+1:0]    rem_d;
  logic [H-1:0]    root_d;

  // One trial-subtract/restore step: bring down the next two radicand bits and
  // subtract 4*root+1 only when it fits, which also makes underflow impossible.
  always_comb begin
    rem_t  = (H+2)'({rem_q, shift_q[W-1:W-2]});
    trial  = {root_q, 2'b01};
    take   = (rem_t >= trial);
    rem_d  = take ? (rem_t - trial) : rem_t;
    root_d = {root_q[H-2:0], take};
  end

  // Control FSM with registered handshake/status outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_root_q  <= '0;
      out_rem_q   <= '0;
      out_exact_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            shift_q    <= in_radicand;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= CW'(H - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          root_q  <= root_d;
          shift_q <= {shift_q[W-3:0], 2'b00};
          if (cnt_q == '0) begin
            // Final remainder is at most 2*root, so the top bit is always zero.
            out_root_q  <= root_d;
            out_rem_q   <= rem_d[H:0];
            out_exact_q <= (rem_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // Result held until consumed; a new radicand waits one more cycle in IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_root  = out_root_q;
  assign out_rem   = out_rem_q;
  assign out_exact = out_exact_q;

endmodule
